// File: rtl/dprio_c3gxb_pkg.sv
// Shared types and constants for the c3gxb DPRIO responder.
// Covers the FSM states, the register-window decode and the calibration field positions.
package dprio_c3gxb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR_FRAME,
    DATA_FRAME,
    COMPLETE
  } state_t;

  localparam logic [7:0] WIN_BASE   = 8'hC0;
  localparam logic [3:0] REG_C01    = 4'd1;
  localparam logic [3:0] REG_C02    = 4'd2;
  localparam int         CAL_MSB    = 10;
  localparam int         CAL_LSB    = 3;
  localparam int         CAL_EN_BIT = 6;

  // A single channel still needs a one-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dprio_resp_regbank.sv
// Per-channel 16 x 16-bit register window with reset initialisation.
// Provides one write port, one read port and parallel C01/C02 taps for the testbus comparators.
module dprio_resp_regbank
  import dprio_c3gxb_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter logic [15:0] C02_INIT     = 16'h0004,
  parameter logic [15:0] REG_INIT     = 16'h0000,
  parameter int          CH_W         = ch_width(NUM_CHANNELS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [CH_W-1:0]               wr_ch,
  input  logic [3:0]                    wr_idx,
  input  logic [15:0]                   wr_data,
  input  logic [CH_W-1:0]               rd_ch,
  input  logic [3:0]                    rd_idx,
  output logic [15:0]                   rd_data,
  output logic [NUM_CHANNELS-1:0][15:0] c01_taps,
  output logic [NUM_CHANNELS-1:0][15:0] c02_taps
);

  logic [15:0] mem [NUM_CHANNELS][16];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int r = 0; r < 16; r++) begin
          mem[c][r] <= (4'(r) == REG_C02) ? C02_INIT : REG_INIT;
        end
      end
    end else if (wr_en) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_ch == CH_W'(c)) mem[c][wr_idx] <= wr_data;
      end
    end
  end

  // Channel selects beyond NUM_CHANNELS read as zero rather than indexing out of range.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (rd_ch == CH_W'(c)) rd_data = mem[c][rd_idx];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      c01_taps[c] = mem[c][REG_C01];
      c02_taps[c] = mem[c][REG_C02];
    end
  end

endmodule

// File: rtl/dprio_resp_c3gxb.sv
// DPRIO responder: serial address/data frame timing with busy handshake over a 0xC00-0xC0F window.
// Optional per-channel testbus comparators are built when DPRIO_RESP_TESTBUS_EN is defined.
module dprio_resp_c3gxb
  import dprio_c3gxb_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          FRAME_CYCLES = 34,
  parameter logic [15:0] C02_INIT     = 16'h0004,
  parameter logic [15:0] REG_INIT     = 16'h0000,
  parameter logic [7:0]  TB_THRESH    = 8'h30
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [15:0]             dprio_addr,
  input  logic [8:0]              quad_addr,
  input  logic [15:0]             dprio_wrdata,
  input  logic                    dprio_wren,
  input  logic                    dprio_rden,
  input  logic                    retain_addr,
  output logic                    dprio_busy,
  output logic [15:0]             dprio_rddata,
  output logic                    protocol_err,
  output logic [NUM_CHANNELS-1:0] testbuses
);

  localparam int         CH_W       = ch_width(NUM_CHANNELS);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_CYCLES - 1);
  localparam logic [10:0] NCH       = 11'(NUM_CHANNELS);

  state_t      state, state_next;
  logic [7:0]  frame_cnt;
  logic        in_frame, frame_done, req, retain_ok;
  logic [15:0] cur_addr, last_addr, cur_data;
  logic [8:0]  cur_quad, last_quad;
  logic        cur_write, last_valid;
  logic [9:0]  cur_ch;
  logic        hit, bank_wr_en;
  logic [15:0] bank_rd_data;
  logic [NUM_CHANNELS-1:0][15:0] c01_taps, c02_taps;
  logic        unused_taps;

  assign req        = dprio_wren | dprio_rden;
  assign retain_ok  = dprio_wren & retain_addr & last_valid;
  assign in_frame   = (state == ADDR_FRAME) || (state == DATA_FRAME);
  assign frame_done = in_frame && (frame_cnt == FRAME_LAST);
  assign dprio_busy = in_frame;

  assign cur_ch     = {cur_quad[7:0], cur_addr[13:12]};
  assign hit        = (cur_addr[15:14] == 2'b00) && !cur_quad[8] &&
                      (cur_addr[11:4] == WIN_BASE) && ({1'b0, cur_ch} < NCH);
  assign bank_wr_en = (state == COMPLETE) && cur_write && hit;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (req) state_next = retain_ok ? DATA_FRAME : ADDR_FRAME;
      ADDR_FRAME: if (frame_done) state_next = DATA_FRAME;
      DATA_FRAME: if (frame_done) state_next = COMPLETE;
      COMPLETE:   state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Read data is captured on the last data-frame cycle so it is already valid in COMPLETE.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt    <= '0;
      last_valid   <= 1'b0;
      last_addr    <= '0;
      last_quad    <= '0;
      cur_addr     <= '0;
      cur_quad     <= '0;
      cur_data     <= '0;
      cur_write    <= 1'b0;
      dprio_rddata <= '0;
      protocol_err <= 1'b0;
    end else begin
      frame_cnt    <= (in_frame && !frame_done) ? frame_cnt + 8'd1 : 8'd0;
      protocol_err <= (state == IDLE) ?
                      (dprio_wren && (dprio_rden || (retain_addr && !last_valid))) : req;
      if (state == IDLE && req) begin
        cur_write <= dprio_wren;
        cur_data  <= dprio_wrdata;
        cur_addr  <= retain_ok ? last_addr : dprio_addr;
        cur_quad  <= retain_ok ? last_quad : quad_addr;
      end
      if (state == ADDR_FRAME && frame_done) begin
        last_valid <= 1'b1;
        last_addr  <= cur_addr;
        last_quad  <= cur_quad;
      end
      if (state == DATA_FRAME && frame_done && !cur_write) begin
        dprio_rddata <= hit ? bank_rd_data : 16'h0000;
      end
    end
  end

  dprio_resp_regbank #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .C02_INIT     (C02_INIT),
    .REG_INIT     (REG_INIT),
    .CH_W         (CH_W)
  ) u_regbank (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (bank_wr_en),
    .wr_ch    (cur_ch[CH_W-1:0]),
    .wr_idx   (cur_addr[3:0]),
    .wr_data  (cur_data),
    .rd_ch    (cur_ch[CH_W-1:0]),
    .rd_idx   (cur_addr[3:0]),
    .rd_data  (bank_rd_data),
    .c01_taps (c01_taps),
    .c02_taps (c02_taps)
  );

`ifdef DPRIO_RESP_TESTBUS_EN
  // Comparator trips once calibration is enabled and the code reaches the threshold.
  always_ff @(posedge clock) begin
    if (reset) begin
      testbuses <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        testbuses[c] <= c02_taps[c][CAL_EN_BIT] &&
                        (c01_taps[c][CAL_MSB:CAL_LSB] >= TB_THRESH);
      end
    end
  end
  assign unused_taps = ^{c01_taps, c02_taps};
`else
  assign testbuses   = '0;
  assign unused_taps = ^{c01_taps, c02_taps, TB_THRESH};
`endif

endmodule

// File: tb/tb_dprio_resp_c3gxb.sv
// Directed self-checking bench for dprio_resp_c3gxb at default parameters.
// Testbus steps are checked against the comparator when DPRIO_RESP_TESTBUS_EN is defined, else against zero.
module tb_dprio_resp_c3gxb;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] dprio_addr, dprio_wrdata;
  logic [8:0]  quad_addr;
  logic        dprio_wren, dprio_rden, retain_addr;
  logic        dprio_busy, protocol_err;
  logic [15:0] dprio_rddata;
  logic [3:0]  testbuses;

  int checks = 0;
  int errors = 0;

  dprio_resp_c3gxb dut (
    .clock        (clock),
    .reset        (reset),
    .dprio_addr   (dprio_addr),
    .quad_addr    (quad_addr),
    .dprio_wrdata (dprio_wrdata),
    .dprio_wren   (dprio_wren),
    .dprio_rden   (dprio_rden),
    .retain_addr  (retain_addr),
    .dprio_busy   (dprio_busy),
    .dprio_rddata (dprio_rddata),
    .protocol_err (protocol_err),
    .testbuses    (testbuses)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle; called and returns on a falling edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic ret,
                               input logic [15:0] addr, input logic [8:0] quad, input logic [15:0] data);
    dprio_wren   = wr;
    dprio_rden   = rd;
    retain_addr  = ret;
    dprio_addr   = addr;
    quad_addr    = quad;
    dprio_wrdata = data;
    @(negedge clock);
    dprio_wren   = 1'b0;
    dprio_rden   = 1'b0;
    retain_addr  = 1'b0;
    dprio_addr   = 16'h0000;
    quad_addr    = 9'h000;
    dprio_wrdata = 16'h0000;
  endtask

  task automatic waitIdle(output int busy_len, output logic err_seen);
    busy_len = 0;
    err_seen = 1'b0;
    while (dprio_busy === 1'b1 && busy_len < 200) begin
      err_seen = err_seen | protocol_err;
      busy_len++;
      @(negedge clock);
    end
  endtask

  // Returns on the first idle cycle after COMPLETE.
  task automatic runTransaction(input logic wr, input logic rd, input logic ret,
                                input logic [15:0] addr, input logic [8:0] quad, input logic [15:0] data,
                                output int busy_len, output logic err_seen);
    applyStimulus(wr, rd, ret, addr, quad, data);
    waitIdle(busy_len, err_seen);
    @(negedge clock);
  endtask

  task automatic readReg(input logic [15:0] addr, input logic [8:0] quad, output logic [15:0] data);
    int   len;
    logic err;
    runTransaction(1'b0, 1'b1, 1'b0, addr, quad, 16'h0000, len, err);
    data = dprio_rddata;
  endtask

  task automatic writeReg(input logic [15:0] addr, input logic [15:0] data);
    int   len;
    logic err;
    runTransaction(1'b1, 1'b0, 1'b0, addr, 9'h000, data, len, err);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int          len;
    logic        err;
    logic [15:0] rd;

    dprio_wren = 1'b0; dprio_rden = 1'b0; retain_addr = 1'b0;
    dprio_addr = 16'h0000; quad_addr = 9'h000; dprio_wrdata = 16'h0000;
    reset = 1'b1;
    @(negedge clock);
    doReset();

    checkOutput("reset_busy", 32'(dprio_busy), 32'h0);
    checkOutput("reset_rddata", 32'(dprio_rddata), 32'h0);
    checkOutput("reset_err", 32'(protocol_err), 32'h0);
    checkOutput("reset_testbus", 32'(testbuses), 32'h0);

    // Read of C02 after reset: 68 busy cycles, init value returned
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h2C02, 9'h000, 16'h0000);
    waitIdle(len, err);
    checkOutput("read_busy_len", 32'(len), 32'd68);
    checkOutput("read_busy_low", 32'(dprio_busy), 32'h0);
    checkOutput("read_c02_init", 32'(dprio_rddata), 32'h0004);
    checkOutput("read_no_err", 32'(err), 32'h0);
    @(negedge clock);

    // Write then read back, neighbouring channel untouched
    runTransaction(1'b1, 1'b0, 1'b0, 16'h1C05, 9'h000, 16'hA5A5, len, err);
    checkOutput("write_busy_len", 32'(len), 32'd68);
    checkOutput("write_keeps_rddata", 32'(dprio_rddata), 32'h0004);
    readReg(16'h1C05, 9'h000, rd);
    checkOutput("readback_ch1_c05", 32'(rd), 32'hA5A5);
    readReg(16'h0C05, 9'h000, rd);
    checkOutput("readback_ch0_c05", 32'(rd), 32'h0000);

    // Retained-address write reuses ch0 C01
    writeReg(16'h0C01, 16'h1234);
    runTransaction(1'b1, 1'b0, 1'b1, 16'h1C07, 9'h000, 16'h5678, len, err);
    checkOutput("retain_busy_len", 32'(len), 32'd34);
    checkOutput("retain_no_err", 32'(err), 32'h0);
    readReg(16'h0C01, 9'h000, rd);
    checkOutput("retain_target", 32'(rd), 32'h5678);
    readReg(16'h1C07, 9'h000, rd);
    checkOutput("retain_presented_addr", 32'(rd), 32'h0000);

    // Read request during busy is rejected with an error pulse
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1C05, 9'h000, 16'h0000);
    repeat (5) @(negedge clock);
    dprio_rden = 1'b1;
    dprio_addr = 16'h0C01;
    @(negedge clock);
    dprio_rden = 1'b0;
    dprio_addr = 16'h0000;
    checkOutput("busy_req_err", 32'(protocol_err), 32'h1);
    @(negedge clock);
    checkOutput("busy_req_err_clear", 32'(protocol_err), 32'h0);
    waitIdle(len, err);
    checkOutput("busy_req_remaining", 32'(len), 32'd61);
    checkOutput("busy_req_data_intact", 32'(dprio_rddata), 32'hA5A5);
    @(negedge clock);

    // Retain with no valid last address after reset
    doReset();
    runTransaction(1'b1, 1'b0, 1'b1, 16'h0C03, 9'h000, 16'h00FF, len, err);
    checkOutput("retain_invalid_err", 32'(err), 32'h1);
    checkOutput("retain_invalid_len", 32'(len), 32'd68);
    readReg(16'h1C05, 9'h000, rd);
    checkOutput("reset_clears_reg", 32'(rd), 32'h0000);
    readReg(16'h0C03, 9'h000, rd);
    checkOutput("retain_invalid_target", 32'(rd), 32'h00FF);

    // wren and rden together act as a write plus an error
    runTransaction(1'b1, 1'b1, 1'b0, 16'h0C04, 9'h000, 16'hBEEF, len, err);
    checkOutput("both_err", 32'(err), 32'h1);
    checkOutput("both_keeps_rddata", 32'(dprio_rddata), 32'h00FF);
    readReg(16'h0C04, 9'h000, rd);
    checkOutput("both_wrote", 32'(rd), 32'hBEEF);

    // Misses
    readReg(16'h0C02, 9'h001, rd);
    checkOutput("miss_quad_read", 32'(rd), 32'h0000);
    writeReg(16'h0D00, 16'hFFFF);
    readReg(16'h0D00, 9'h000, rd);
    checkOutput("miss_d00_read", 32'(rd), 32'h0000);
    readReg(16'h0C00, 9'h000, rd);
    checkOutput("miss_d00_no_alias", 32'(rd), 32'h0000);

    // Reset at T+10 of a write aborts it
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0C04, 9'h000, 16'h1111);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_busy_low", 32'(dprio_busy), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    readReg(16'h0C04, 9'h000, rd);
    checkOutput("abort_no_write", 32'(rd), 32'h0000);

    // Testbus comparator on channel 0
    writeReg(16'h0C02, 16'h0044);
    writeReg(16'h0C01, 16'h0178);
    @(negedge clock);
    checkOutput("tb_below_thresh", 32'(testbuses), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0C01, 9'h000, 16'h0180);
    waitIdle(len, err);
    @(negedge clock);
    checkOutput("tb_at_thresh_early", 32'(testbuses), 32'h0);
    @(negedge clock);
`ifdef DPRIO_RESP_TESTBUS_EN
    checkOutput("tb_at_thresh", 32'(testbuses), 32'h1);
`else
    checkOutput("tb_at_thresh", 32'(testbuses), 32'h0);
`endif
    writeReg(16'h0C02, 16'h0004);
    @(negedge clock);
    checkOutput("tb_cal_disabled", 32'(testbuses), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dprio_resp_c3gxb.md
Name: dprio_resp_c3gxb

Overview:
- Responder end of the DPRIO register-access interface driven by the transceiver offset-calibration and reconfiguration initiators.
- Models the serial DPRIO frame timing with a busy handshake.
- Holds a 16-register window at 0xC00–0xC0F per channel.
- Returns read data; optionally drives per-channel testbus bits derived from register contents, for closed-loop calibration benches and FPGA self-test.

Parameters:
- NUM_CHANNELS, 4, number of modelled channels; 1..1024.
- FRAME_CYCLES, 34, clock cycles per serial frame (address or data); >=2.
- C02_INIT, 16'h0004, reset value of register 0xC02 in every channel; bit 2 set means calibration is required.
- REG_INIT, 16'h0000, reset value of all other registers.
- TB_THRESH, 8'h30, testbus trip threshold; used only with the optional feature.

Ports:
- clock  in  1  reconfig clock
- reset  in  1  synchronous, active-high
- dprio_addr  in  16  {2'b00, chan_lo[1:0], reg_addr[11:0]}
- quad_addr  in  9  {1'b0, chan_hi[7:0]}
- dprio_wrdata  in  16  write data
- dprio_wren  in  1  write request, sampled when idle
- dprio_rden  in  1  read request, sampled when idle
- retain_addr  in  1  write only: skip the address frame and reuse the last latched address
- dprio_busy  out  1  transaction in progress
- dprio_rddata  out  16  read data
- protocol_err  out  1  one-cycle error pulse
- testbuses  out  NUM_CHANNELS  per-channel comparator bits

Behaviour:
- Clock and reset: clock is clock; reset is reset, synchronous, active-high.
- Reset values: dprio_busy=0, dprio_rddata=0, protocol_err=0, testbuses=0, last-address-valid=0. Register 0xC02 of every channel = C02_INIT; all other registers = REG_INIT.
- Reset mid-transaction aborts it: busy low the next cycle, no register update.
- Address decode:
  - ch = {quad_addr[7:0], dprio_addr[13:12]}.
  - Hit when dprio_addr[15:14]=0, quad_addr[8]=0, dprio_addr[11:4]=8'hC0 and ch<NUM_CHANNELS.
  - Register index = dprio_addr[3:0].
- FSM states: IDLE, ADDR_FRAME, DATA_FRAME, COMPLETE.
- IDLE:
  - Request = wren|rden. A request in cycle T latches address, data and type; dprio_busy=1 from T+1.
  - wren&rden together: treated as write, protocol_err pulse at T+1.
  - Next state is ADDR_FRAME, or DATA_FRAME when write & retain_addr & last-address-valid.
  - retain_addr with no valid last address: protocol_err pulse, full address frame using the incoming address.
  - retain_addr with rden: ignored.
- ADDR_FRAME: FRAME_CYCLES cycles; then DATA_FRAME. Every completed address frame sets last-address-valid and updates the last address.
- DATA_FRAME: FRAME_CYCLES cycles; then COMPLETE.
- COMPLETE (one cycle):
  - Write hit: register updated.
  - Write miss: silently dropped.
  - Read: dprio_rddata = register value on a hit, 16'h0000 on a miss.
  - dprio_busy=0 in this cycle; next state IDLE.
- Latency from request cycle T to busy deassertion:
  - full transaction: T+1+2*FRAME_CYCLES (T+69 at default);
  - retained write: T+1+FRAME_CYCLES.
- dprio_rddata holds its value until the next read completes; it is unaffected by writes.
- wren/rden while busy: ignored, protocol_err pulse in the next cycle; the transaction in flight is unaffected.
- A request arriving in the COMPLETE cycle is ignored with an error. A request in the first IDLE cycle after COMPLETE is accepted.
- Frame counter is 8 bits; it counts 0..FRAME_CYCLES-1 and does not wrap.

Optional Feature:
- Macro DPRIO_RESP_TESTBUS_EN.
- When defined:
  - testbuses[ch] is registered, one cycle after a register change.
  - testbuses[ch] = C02[6] & (C01[10:3] >= TB_THRESH), where C02/C01 are that channel's registers 0xC02/0xC01.
  - This models the offset comparator tripping as the calibration code rises.
- When undefined: testbuses is tied to 0 and no comparator logic is built.

Decomposition:
- Shared package dprio_c3gxb_pkg:
  - state enum;
  - window base constant 8'hC0;
  - register indices REG_C01=1, REG_C02=2;
  - cal field position [10:3] and cal_en bit 6.
- One sub-module, dprio_resp_regbank: channel × 16 × 16 storage with reset init, one write port, one read port, and parallel C01/C02 taps per channel for the testbus logic.

Test Plan:
- Read after reset: rden pulse to ch2 addr 0x2C02 (dprio_addr=16'h2C02, quad_addr=0) → busy high cycles T+1..T+68, low at T+69, dprio_rddata=16'h0004.
- Write then read: write 16'hA5A5 to ch1 reg 0xC05, then read it back → 16'hA5A5; ch0 reg 0xC05 still reads 16'h0000.
- Retained write: write 0xC01 ch0, then write with retain_addr=1 → busy lasts 34 cycles; target is 0xC01 ch0 regardless of the dprio_addr presented.
- Errors:
  - rden during busy → protocol_err pulse, in-flight read data intact;
  - retain_addr write immediately after reset → protocol_err and a 68-cycle busy;
  - wren+rden together → write performed and protocol_err pulsed.
- Miss handling: read quad_addr=1 with NUM_CHANNELS=4 → rddata=0; write to 0xD00 → no register changes. Reset asserted at T+10 of a write → busy low next cycle, target register unchanged.
- Testbus (macro on): set C02=16'h0044, step C01[10:3] through 0x2F then 0x30 → testbuses[0] goes 0 then 1 one cycle after the write completes. Clearing C02[6] → 0.
